// File: rtl/qoi_chunk_encoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | qoi_chunk_encoder_if : pixel-in / encoded-byte-out handshake bundle    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
interface qoi_chunk_encoder_if;
   logic        px_valid;
   logic        px_ready;
   logic [31:0] px_data;
   logic        px_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;

   modport master (
      output px_valid, px_data, px_last, out_ready,
      input  px_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  px_valid, px_data, px_last, out_ready,
      output px_ready, out_valid, out_data, out_last
   );
endinterface
`default_nettype wire

// File: rtl/qoi_chunk_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | qoi_chunk_encoder : streaming QOI op selection and byte emitter;       |
// | QOI_END_MARKER_EN appends the 8-byte end marker.  Revision 1.0         |
// +-----------------------------------------------------------------------+
module qoi_chunk_encoder #(
   parameter int RUN_MAX     = 62,
   parameter int INDEX_DEPTH = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   output logic               busy_o,
   qoi_chunk_encoder_if.slave bus
);

   localparam int C_RUN_W = $clog2(RUN_MAX + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_CLASSIFY = 3'd2;
   localparam logic [2:0] S_EMIT     = 3'd3;
`ifdef QOI_END_MARKER_EN
   localparam logic [2:0] S_MARKER   = 3'd4;
   localparam logic [2:0] S_DONE     = S_MARKER;
`else
   localparam logic [2:0] S_DONE     = S_IDLE;
`endif

   logic [2:0]             state_q, state_d;
   logic [31:0]            px_q;
   logic [31:0]            prev_q;
   logic                   last_q;
   logic [C_RUN_W-1:0]     run_q;
   logic [INDEX_DEPTH-1:0] valid_q;
   logic [31:0]            index_q [INDEX_DEPTH];
   logic [5:0][7:0]        buf_q;
   logic [2:0]             cnt_q;
   logic [2:0]             ptr_q;
`ifdef QOI_END_MARKER_EN
   logic [2:0]             mcnt_q;
`endif

   logic                   w_same;
   logic [5:0]             w_hash;
   logic [31:0]            w_idx_rd;
   logic                   w_hit;
   logic                   w_idx_we;
   logic signed [7:0]      w_dr, w_dg, w_db;
   logic signed [8:0]      w_drg, w_dbg;
   logic                   w_is_diff;
   logic                   w_is_luma;
   logic [4:0][7:0]        w_op;
   logic [2:0]             w_op_len;
   logic [5:0][7:0]        w_buf;
   logic [2:0]             w_cnt;
   logic [C_RUN_W-1:0]     w_run_inc;
   logic [C_RUN_W-1:0]     w_run_d;
   logic                   w_last_byte;

   function automatic logic [7:0] f_run_byte(input logic [C_RUN_W-1:0] n);
      return {2'b11, 6'(n - 1'b1)};
   endfunction

   assign w_last_byte = (ptr_q == cnt_q - 3'd1);

   // Chunk selection for the registered pixel against the previous pixel.
   always_comb begin
      w_same   = (px_q == prev_q);
      w_hash   = 6'(12'(px_q[31:24]) * 12'd3 + 12'(px_q[23:16]) * 12'd5
                   + 12'(px_q[15:8]) * 12'd7 + 12'(px_q[7:0]) * 12'd11);
      w_idx_rd = valid_q[w_hash] ? index_q[w_hash] : 32'h0;
      w_hit    = (w_idx_rd == px_q);
      w_idx_we = !w_same && !w_hit;

      w_dr  = px_q[31:24] - prev_q[31:24];
      w_dg  = px_q[23:16] - prev_q[23:16];
      w_db  = px_q[15:8]  - prev_q[15:8];
      w_drg = {w_dr[7], w_dr} - {w_dg[7], w_dg};
      w_dbg = {w_db[7], w_db} - {w_dg[7], w_dg};

      w_is_diff = (w_dr >= -8'sd2) && (w_dr <= 8'sd1)
               && (w_dg >= -8'sd2) && (w_dg <= 8'sd1)
               && (w_db >= -8'sd2) && (w_db <= 8'sd1);
      w_is_luma = (w_dg >= -8'sd32) && (w_dg <= 8'sd31)
               && (w_drg >= -9'sd8) && (w_drg <= 9'sd7)
               && (w_dbg >= -9'sd8) && (w_dbg <= 9'sd7);

      w_op     = '0;
      w_op_len = 3'd1;
      if (w_hit) begin
         w_op[0] = {2'b00, w_hash};
      end else if (px_q[7:0] != prev_q[7:0]) begin
         w_op[0]  = 8'hFF;
         w_op[1]  = px_q[31:24];
         w_op[2]  = px_q[23:16];
         w_op[3]  = px_q[15:8];
         w_op[4]  = px_q[7:0];
         w_op_len = 3'd5;
      end else if (w_is_diff) begin
         w_op[0] = {2'b01, 2'(w_dr + 8'sd2), 2'(w_dg + 8'sd2), 2'(w_db + 8'sd2)};
      end else if (w_is_luma) begin
         w_op[0]  = {2'b10, 6'(w_dg + 8'sd32)};
         w_op[1]  = {4'(w_drg + 9'sd8), 4'(w_dbg + 9'sd8)};
         w_op_len = 3'd2;
      end else begin
         w_op[0]  = 8'hFE;
         w_op[1]  = px_q[31:24];
         w_op[2]  = px_q[23:16];
         w_op[3]  = px_q[15:8];
         w_op_len = 3'd4;
      end

      w_run_inc = run_q + 1'b1;
      w_buf     = '0;
      w_cnt     = 3'd0;
      w_run_d   = run_q;
      if (w_same) begin
         if ((w_run_inc == C_RUN_W'(RUN_MAX)) || last_q) begin
            w_buf[0] = f_run_byte(w_run_inc);
            w_cnt    = 3'd1;
            w_run_d  = '0;
         end else begin
            w_run_d  = w_run_inc;
         end
      end else begin
         w_run_d = '0;
         if (run_q != '0) begin
            w_buf[0]   = f_run_byte(run_q);
            w_buf[5:1] = w_op;
            w_cnt      = w_op_len + 3'd1;
         end else begin
            w_buf[4:0] = w_op;
            w_cnt      = w_op_len;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (bus.px_valid) state_d = S_CLASSIFY;
         end
         S_CLASSIFY: begin
            if (w_cnt != 3'd0)  state_d = S_EMIT;
            else if (last_q)    state_d = S_DONE;
            else                state_d = S_LOAD;
         end
         S_EMIT: begin
            if (bus.out_ready && w_last_byte) state_d = last_q ? S_DONE : S_LOAD;
         end
`ifdef QOI_END_MARKER_EN
         S_MARKER: begin
            if (bus.out_ready && (mcnt_q == 3'd7)) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.px_ready  = (state_q == S_LOAD);
      bus.out_valid = 1'b0;
      bus.out_data  = 8'h00;
      bus.out_last  = 1'b0;
      busy_o        = (state_q != S_IDLE);
      case (state_q)
         S_EMIT: begin
            bus.out_valid = 1'b1;
            bus.out_data  = buf_q[ptr_q];
`ifndef QOI_END_MARKER_EN
            bus.out_last  = last_q && w_last_byte;
`endif
         end
`ifdef QOI_END_MARKER_EN
         S_MARKER: begin
            bus.out_valid = 1'b1;
            bus.out_data  = (mcnt_q == 3'd7) ? 8'h01 : 8'h00;
            bus.out_last  = (mcnt_q == 3'd7);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         px_q    <= '0;
         prev_q  <= 32'h0000_00FF;
         last_q  <= 1'b0;
         run_q   <= '0;
         valid_q <= '0;
         buf_q   <= '0;
         cnt_q   <= 3'd0;
         ptr_q   <= 3'd0;
`ifdef QOI_END_MARKER_EN
         mcnt_q  <= 3'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef QOI_END_MARKER_EN
               mcnt_q <= 3'd0;
`endif
               if (start_i) begin
                  prev_q  <= 32'h0000_00FF;
                  run_q   <= '0;
                  valid_q <= '0;
               end
            end
            S_LOAD: begin
               if (bus.px_valid) begin
                  px_q   <= bus.px_data;
                  last_q <= bus.px_last;
               end
            end
            S_CLASSIFY: begin
               prev_q <= px_q;
               run_q  <= w_run_d;
               buf_q  <= w_buf;
               cnt_q  <= w_cnt;
               ptr_q  <= 3'd0;
               if (w_idx_we) valid_q[w_hash] <= 1'b1;
            end
            S_EMIT: begin
               if (bus.out_ready) ptr_q <= ptr_q + 3'd1;
            end
`ifdef QOI_END_MARKER_EN
            S_MARKER: begin
               if (bus.out_ready) mcnt_q <= mcnt_q + 3'd1;
            end
`endif
            default: ;
         endcase
      end
   end

   // Entry contents need no reset: the valid bits gate every read.
   always_ff @(posedge clk) begin
      if ((state_q == S_CLASSIFY) && w_idx_we) begin
         index_q[w_hash] <= px_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qoi_chunk_encoder.sv
`default_nettype none
// tb_qoi_chunk_encoder : directed and random images checked against a
// byte-level QOI encoder model.
module tb_qoi_chunk_encoder;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic start_i = 1'b0;
   logic busy_o;

   qoi_chunk_encoder_if bus ();

   qoi_chunk_encoder #(
      .RUN_MAX     (62),
      .INDEX_DEPTH (64)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .busy_o  (busy_o),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          checks    = 0;
   int          failures  = 0;
   int          sink_mode = 0;
   logic [31:0] img_q[$];
   logic [7:0]  mq[$];
   logic [7:0]  lit_q[$];
   logic [7:0]  exp_q[$];
   logic        exp_last_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int sw8(input int x);
      int v;
      v = x & 255;
      return (v > 127) ? v - 256 : v;
   endfunction

   // Reference encoder: whole image in, byte list out.
   function automatic void run_model();
      logic [31:0] idx [64];
      logic [31:0] prev, p;
      int run, h, r, g, b, a, pr, pg, pb, pa, dr, dg, db;
      mq.delete();
      foreach (idx[i]) idx[i] = 32'h0;
      prev = 32'h0000_00FF;
      run  = 0;
      for (int k = 0; k < img_q.size(); k++) begin
         p  = img_q[k];
         r  = int'(p[31:24]);  g  = int'(p[23:16]);  b  = int'(p[15:8]);  a  = int'(p[7:0]);
         pr = int'(prev[31:24]); pg = int'(prev[23:16]); pb = int'(prev[15:8]); pa = int'(prev[7:0]);
         if (p == prev) begin
            run++;
            if (run == 62 || k == img_q.size() - 1) begin
               mq.push_back(8'(192 + run - 1));
               run = 0;
            end
         end else begin
            if (run > 0) begin
               mq.push_back(8'(192 + run - 1));
               run = 0;
            end
            h = (r * 3 + g * 5 + b * 7 + a * 11) % 64;
            if (idx[h] == p) begin
               mq.push_back(8'(h));
            end else begin
               idx[h] = p;
               dr = sw8(r - pr); dg = sw8(g - pg); db = sw8(b - pb);
               if (a != pa) begin
                  mq.push_back(8'hFF); mq.push_back(8'(r)); mq.push_back(8'(g));
                  mq.push_back(8'(b)); mq.push_back(8'(a));
               end else if (dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 && db >= -2 && db <= 1) begin
                  mq.push_back(8'(64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2)));
               end else if (dg >= -32 && dg <= 31 && dr - dg >= -8 && dr - dg <= 7
                            && db - dg >= -8 && db - dg <= 7) begin
                  mq.push_back(8'(128 + dg + 32));
                  mq.push_back(8'((dr - dg + 8) * 16 + (db - dg + 8)));
               end else begin
                  mq.push_back(8'hFE); mq.push_back(8'(r)); mq.push_back(8'(g)); mq.push_back(8'(b));
               end
            end
         end
         prev = p;
      end
`ifdef QOI_END_MARKER_EN
      repeat (7) mq.push_back(8'h00);
      mq.push_back(8'h01);
`endif
   endfunction

   task automatic check_model(input string name);
`ifdef QOI_END_MARKER_EN
      repeat (7) lit_q.push_back(8'h00);
      lit_q.push_back(8'h01);
`endif
      run_model();
      chk({name, "_len"}, mq.size(), lit_q.size());
      for (int i = 0; i < lit_q.size() && i < mq.size(); i++) chk(name, mq[i], lit_q[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.px_valid = 1'b0;
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      exp_last_q.delete();
      rst = 1'b1;
   endtask

   task automatic run_image(input int gap);
      int k, cyc, n;
      run_model();
      foreach (mq[i]) begin
         exp_q.push_back(mq[i]);
         exp_last_q.push_back(i == mq.size() - 1);
      end
      n = img_q.size();
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      k = 0; cyc = 0;
      while (k < n && cyc < 200 * n + 50) begin
         @(negedge clk);
         cyc++;
         start_i = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) < gap) begin
            bus.px_valid = 1'b0;
         end else begin
            bus.px_valid = 1'b1;
            bus.px_data  = img_q[k];
            bus.px_last  = (k == n - 1);
         end
         #1;
         if (bus.px_valid && bus.px_ready) k++;
      end
      @(negedge clk);
      bus.px_valid = 1'b0;
      bus.px_last  = 1'b0;
      start_i      = 1'b0;
      chk("pixels_accepted", k, n);
      cyc = 0;
      while ((exp_q.size() != 0 || busy_o) && cyc < 3000) begin
         @(negedge clk); #2;
         cyc++;
      end
      chk("image_complete", (exp_q.size() == 0 && !busy_o), 1);
      if (exp_q.size() != 0 || busy_o || k != n) do_reset();
   endtask

   task automatic gen_image(input int n);
      logic [31:0] cur;
      int sel, rep, d;
      cur = 32'h0000_00FF;
      img_q.delete();
      while (img_q.size() < n) begin
         sel = $urandom_range(0, 9);
         case (sel)
            2: if (img_q.size() > 0) cur = img_q[$urandom_range(0, img_q.size() - 1)];
            3, 4: cur = {8'(cur[31:24] + $urandom_range(0, 3) - 2), 8'(cur[23:16] + $urandom_range(0, 3) - 2),
                         8'(cur[15:8] + $urandom_range(0, 3) - 2), cur[7:0]};
            5: begin
               d   = int'($urandom_range(0, 63)) - 32;
               cur = {8'(int'(cur[31:24]) + d + int'($urandom_range(0, 15)) - 8), 8'(int'(cur[23:16]) + d),
                      8'(int'(cur[15:8]) + d + int'($urandom_range(0, 15)) - 8), cur[7:0]};
            end
            6, 7: cur = {24'($urandom), cur[7:0]};
            8: cur = $urandom;
            9: begin
               rep = $urandom_range(5, 70);
               repeat (rep) if (img_q.size() < n - 1) img_q.push_back(cur);
            end
            default: ;
         endcase
         img_q.push_back(cur);
      end
   endtask

   // Sink: drives out_ready and scores every byte handshake.
   initial begin : cmp
      logic       held;
      logic [7:0] held_data;
      logic       held_last;
      logic       busy_chk;
      logic [7:0] e;
      logic       l;
      held = 1'b0; busy_chk = 1'b0; held_data = 8'h00; held_last = 1'b0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (sink_mode)
            1:       bus.out_ready = 1'b0;
            2:       bus.out_ready = !bus.out_ready;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         if (!rst) begin
            held = 1'b0;
            busy_chk = 1'b0;
         end else begin
            if (busy_chk) begin
               chk("busy_after_last", busy_o, 0);
               busy_chk = 1'b0;
            end
            if (bus.out_valid) begin
               chk("px_ready_while_emitting", bus.px_ready, 0);
               if (held) begin
                  chk("stall_data", bus.out_data, held_data);
                  chk("stall_last", bus.out_last, held_last);
               end
               if (bus.out_ready) begin
                  held = 1'b0;
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_byte got=%h want=none at %0t", bus.out_data, $time);
                  end else begin
                     e = exp_q.pop_front();
                     l = exp_last_q.pop_front();
                     chk("out_data", bus.out_data, e);
                     chk("out_last", bus.out_last, l);
                     if (l) busy_chk = 1'b1;
                  end
               end else begin
                  held      = 1'b1;
                  held_data = bus.out_data;
                  held_last = bus.out_last;
               end
            end else if (held) begin
               chk("stall_valid", bus.out_valid, 1);
               held = 1'b0;
            end
         end
      end
   end

   initial begin : main
      bus.px_valid = 1'b0;
      bus.px_data  = 32'h0;
      bus.px_last  = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_px_ready",  bus.px_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last",  bus.out_last,  0);
      chk("rst_out_data",  bus.out_data,  0);
      chk("rst_busy",      busy_o,        0);
      @(negedge clk);
      rst = 1'b1;

      img_q = '{32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF};
      lit_q = '{8'hC2};
      check_model("lit_run3");
      run_image(0);

      img_q = '{32'h0A14_1EFF, 32'h0B14_1DFF, 32'h0A14_1EFF, 32'h1E28_2DFF, 32'h0102_0304};
      lit_q = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h79, 8'h09, 8'hB4, 8'h83,
                8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
      check_model("lit_ops");
      run_image(20);

      img_q.delete();
      repeat (63) img_q.push_back(32'h0000_00FF);
      img_q.push_back(32'h0000_0000);
      lit_q = '{8'hFD, 8'hC0, 8'h00};
      check_model("lit_run63");
      run_image(10);

      sink_mode = 2;
      img_q = '{32'h0000_0040};
      lit_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h40};
      check_model("lit_rgba");
      run_image(0);

      sink_mode = 1;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      bus.px_valid = 1'b1; bus.px_data = 32'h0000_0040; bus.px_last = 1'b1;
      #1 chk("load_px_ready", bus.px_ready, 1);
      @(negedge clk); bus.px_valid = 1'b0; bus.px_last = 1'b0;
      #1 chk("classify_no_valid", bus.out_valid, 0);
      @(negedge clk);
      #1 chk("first_byte_valid", bus.out_valid, 1);
      chk("first_byte_data", bus.out_data, 8'hFF);
      chk("emit_busy", busy_o, 1);
      repeat (2) @(negedge clk);
      #1 chk("stalled_byte_data", bus.out_data, 8'hFF);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      #1 chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_px_ready", bus.px_ready, 0);
      chk("midrst_out_data", bus.out_data, 0);
      sink_mode = 0;
      @(negedge clk); rst = 1'b1;
      img_q = '{32'h0000_0000};
      lit_q = '{8'h00};
      check_model("lit_zero");
      run_image(0);

      for (int t = 0; t < 40; t++) begin
         sink_mode = ($urandom_range(0, 4) == 0) ? 2 : 0;
         gen_image($urandom_range(1, 90));
         run_image($urandom_range(0, 40));
      end
      sink_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
